// File: rtl/complex_mult_bist.sv
// Self-test driver for a streaming complex multiplier. An LFSR generates the
// operands, a 4-deep FIFO holds expected results, and a watchdog bounds the drain.
module complex_mult_bist #(
  parameter int          DATA_WIDTH = 8,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468,
  parameter int          TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    sw_rst,
  input  logic                    sw_clr,
  input  logic                    start,
  input  logic [7:0]              nr_trans,
  output logic                    op_val,
  input  logic                    op_ready,
  output logic [DATA_WIDTH-1:0]   op_1_re,
  output logic [DATA_WIDTH-1:0]   op_1_im,
  output logic [DATA_WIDTH-1:0]   op_2_re,
  output logic [DATA_WIDTH-1:0]   op_2_im,
  input  logic                    res_val,
  output logic                    res_ready,
  input  logic [2*DATA_WIDTH-1:0] result_re,
  input  logic [2*DATA_WIDTH-1:0] result_im,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              err_cnt,
  output logic                    timeout_flag,
  output logic                    unexp_flag
);

  localparam int          DW         = DATA_WIDTH;
  localparam int          RW         = 2 * DATA_WIDTH;
  localparam int          FIFO_DEPTH = 4;
  localparam int          WD_W       = $clog2(TIMEOUT + 1);
  // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [31:0]          lfsr, lfsr_next;
  logic [7:0]           nr_q, issued, received;
  logic [1:0]           wr_ptr, rd_ptr;
  logic [2:0]           count;
  logic [WD_W-1:0]      wd_cnt;
  logic [2*RW-1:0]      exp_mem [FIFO_DEPTH];
  logic signed [RW-1:0] a_re, a_im, b_re, b_im;
  logic signed [RW-1:0] exp_re, exp_im;
  logic [RW-1:0]        head_re, head_im;
  logic                 start_acc, wd_expire;
  logic                 push, pop, res_hs, unexp, mismatch;
  logic                 fifo_full, fifo_empty;

  assign sw_rst = 1'b0;

  assign op_1_re = lfsr[0  +: DW];
  assign op_1_im = lfsr[8  +: DW];
  assign op_2_re = lfsr[16 +: DW];
  assign op_2_im = lfsr[24 +: DW];

  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);

  // Widen to the product width first so the products wrap exactly at 2*DATA_WIDTH.
  assign a_re   = {{DW{op_1_re[DW-1]}}, op_1_re};
  assign a_im   = {{DW{op_1_im[DW-1]}}, op_1_im};
  assign b_re   = {{DW{op_2_re[DW-1]}}, op_2_re};
  assign b_im   = {{DW{op_2_im[DW-1]}}, op_2_im};
  assign exp_re = a_re * b_re - a_im * b_im;
  assign exp_im = a_re * b_im + a_im * b_re;

  assign fifo_full  = (count == 3'(FIFO_DEPTH));
  assign fifo_empty = (count == 3'd0);
  assign {head_re, head_im} = exp_mem[rd_ptr];

  assign push     = op_val && op_ready;
  assign res_hs   = res_val && res_ready;
  assign pop      = res_hs && !fifo_empty;
  assign unexp    = res_hs && fifo_empty;
  assign mismatch = pop && ((result_re != head_re) || (result_im != head_im));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (sw_clr) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    next_state = state;
    op_val     = 1'b0;
    res_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    start_acc  = 1'b0;
    wd_expire  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          start_acc  = 1'b1;
          next_state = (nr_trans == 8'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy      = 1'b1;
        res_ready = 1'b1;
        op_val    = (issued < nr_q) && !fifo_full;
        if (issued == nr_q) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        res_ready = 1'b1;
        // res_ready is always high here, so res_val alone marks a handshake.
        if (received == nr_q) begin
          next_state = S_DONE;
        end else if (!res_val && (wd_cnt == WD_W'(TIMEOUT - 1))) begin
          wd_expire  = 1'b1;
          next_state = S_DONE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr         <= LFSR_SEED;
      nr_q         <= '0;
      issued       <= '0;
      received     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      wd_cnt       <= '0;
      err_cnt      <= '0;
      timeout_flag <= 1'b0;
      unexp_flag   <= 1'b0;
    end else if (sw_clr || start_acc) begin
      // A new run keeps the LFSR running; only a clear reloads the seed.
      if (sw_clr) lfsr <= LFSR_SEED;
      nr_q         <= sw_clr ? 8'd0 : nr_trans;
      issued       <= '0;
      received     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      wd_cnt       <= '0;
      err_cnt      <= '0;
      timeout_flag <= 1'b0;
      unexp_flag   <= 1'b0;
    end else begin
      if (push) begin
        lfsr   <= lfsr_next;
        wr_ptr <= wr_ptr + 2'd1;
        issued <= issued + 8'd1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 2'd1;
        received <= received + 8'd1;
      end
      count <= count + 3'(push) - 3'(pop);
      if ((mismatch || unexp) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (unexp)     unexp_flag   <= 1'b1;
      if (wd_expire) timeout_flag <= 1'b1;
      wd_cnt <= ((state == S_DRAIN) && !res_hs) ? wd_cnt + WD_W'(1) : '0;
    end
  end

  // NOTE: the expected-value storage has no reset; count alone decides which
  // entries are valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) exp_mem[wr_ptr] <= {exp_re, exp_im};
  end

endmodule

// File: tb/tb_complex_mult_bist.sv
// Self-checking bench for complex_mult_bist: a behavioural multiplier responder,
// a reference LFSR, a table of directed runs, random runs and corner sequences.
module tb_complex_mult_bist;

  localparam int          DW   = 8;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam int          TO   = 256;

  localparam int M_GOOD = 0, M_CORRUPT2 = 1, M_SILENT = 2, M_RAND = 3;
  localparam int R_ALWAYS = 0, R_TOGGLE3 = 1, R_RAND = 2;

  logic            clk, rst, sw_rst, sw_clr, start;
  logic [7:0]      nr_trans;
  logic            op_val, op_ready, res_val, res_ready;
  logic [DW-1:0]   op_1_re, op_1_im, op_2_re, op_2_im;
  logic [2*DW-1:0] result_re, result_im;
  logic            busy, done, timeout_flag, unexp_flag;
  logic [7:0]      err_cnt;
  logic [4*DW-1:0] dut_ops;

  typedef struct {
    logic [2*DW-1:0] re;
    logic [2*DW-1:0] im;
  } res_t;

  typedef struct {
    int nr;
    int mode;
    int rdy;
    int exp_err;
    int exp_hs;
    bit exp_to;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  res_t        mq[$];
  logic [31:0] ref_lfsr;
  vec_t        vecs[6];

  complex_mult_bist #(.DATA_WIDTH(DW), .LFSR_SEED(SEED), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .sw_clr(sw_clr), .start(start),
    .nr_trans(nr_trans), .op_val(op_val), .op_ready(op_ready),
    .op_1_re(op_1_re), .op_1_im(op_1_im), .op_2_re(op_2_re), .op_2_im(op_2_im),
    .res_val(res_val), .res_ready(res_ready), .result_re(result_re), .result_im(result_im),
    .busy(busy), .done(done), .err_cnt(err_cnt),
    .timeout_flag(timeout_flag), .unexp_flag(unexp_flag)
  );

  assign dut_ops = {op_2_im, op_2_re, op_1_im, op_1_re};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One step of multiplication by x^-1 modulo x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] poly_low;
    poly_low = '0;
    poly_low[31] = 1'b1;  // x^32 term folded into the shifted-in bit
    poly_low[21] = 1'b1;  // x^22
    poly_low[1]  = 1'b1;  // x^2
    poly_low[0]  = 1'b1;  // x^1
    return (s >> 1) ^ (s[0] ? poly_low : 32'h0);
  endfunction

  function automatic logic [4*DW-1:0] exp_ops(input logic [31:0] s);
    return {s[24 +: DW], s[16 +: DW], s[8 +: DW], s[0 +: DW]};
  endfunction

  function automatic res_t cmul(input logic [DW-1:0] ar, ai, br, bi);
    res_t r;
    int   xr, xi, yr, yi, pr, pi;
    xr = int'($signed(ar));
    xi = int'($signed(ai));
    yr = int'($signed(br));
    yi = int'($signed(bi));
    pr = xr * yr - xi * yi;
    pi = xr * yi + xi * yr;
    r.re = pr[2*DW-1:0];
    r.im = pi[2*DW-1:0];
    return r;
  endfunction

  task automatic check_quiet(input string name);
    check(name, {op_val, res_ready, busy, done, err_cnt, timeout_flag, unexp_flag, sw_rst}, '0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    sw_clr = 1'b1;
    @(negedge clk);
    sw_clr = 1'b0;
    ref_lfsr = SEED;
  endtask

  // Starts a run and plays the multiplier: results return one cycle after the
  // operand handshake (randomly later in M_RAND), optionally corrupted.
  task automatic run_txn(input int n, input int mode, input int rdy, input bit expect_done,
                         input int budget, output int hs, output int n_bad, output int done_lat);
    bit              prev_stall, corrupt;
    logic [4*DW-1:0] prev_ops;
    int              last_hs;
    res_t            r;
    hs = 0; n_bad = 0; done_lat = -1; last_hs = 0;
    prev_stall = 1'b0; prev_ops = '0;
    mq.delete();
    @(negedge clk);
    start = 1'b1; nr_trans = n[7:0]; op_ready = 1'b0; res_val = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_lat = cyc - last_hs;
        break;
      end
      if (prev_stall) check("op_stable_in_stall", dut_ops, prev_ops);
      case (rdy)
        R_ALWAYS:  op_ready = 1'b1;
        R_TOGGLE3: op_ready = ((cyc / 3) % 2) == 0;
        default:   op_ready = 1'($urandom_range(0, 1));
      endcase
      res_val = 1'b0;
      if (mode != M_SILENT && mq.size() > 0) begin
        if (mode != M_RAND || $urandom_range(0, 2) != 0) begin
          res_val = 1'b1;
          result_re = mq[0].re;
          result_im = mq[0].im;
        end
      end
      if (op_val && op_ready) begin
        check("op_sequence", dut_ops, exp_ops(ref_lfsr));
        r = cmul(op_1_re, op_1_im, op_2_re, op_2_im);
        corrupt = 1'b0;
        if (mode == M_CORRUPT2 && hs == 1) begin
          r.im[0] = ~r.im[0];
          corrupt = 1'b1;
        end else if (mode == M_RAND && $urandom_range(0, 3) == 0) begin
          r.re[2*DW-1] = ~r.re[2*DW-1];
          corrupt = 1'b1;
        end
        if (corrupt) n_bad++;
        mq.push_back(r);
        ref_lfsr = lfsr_step(ref_lfsr);
        hs++;
        last_hs = cyc;
      end
      if (res_val && res_ready) void'(mq.pop_front());
      prev_stall = op_val && !op_ready;
      prev_ops   = dut_ops;
    end
    op_ready = 1'b0;
    res_val  = 1'b0;
    if (expect_done) check("done_reached", 64'(done_lat >= 0), 64'd1);
  endtask

  task automatic check_end(input string tag, input int hs, input int exp_hs,
                           input int exp_err, input bit exp_to);
    check({tag, "_handshakes"}, 64'(hs), 64'(exp_hs));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    check({tag, "_timeout_flag"}, 64'(timeout_flag), 64'(exp_to));
    check({tag, "_unexp_flag"}, 64'(unexp_flag), 64'd0);
    check({tag, "_busy_done"}, 64'({busy, done, sw_rst}), 64'b010);
    check({tag, "_lfsr_advance"}, 64'(dut_ops), 64'(exp_ops(ref_lfsr)));
    repeat (2) @(negedge clk);
    check({tag, "_done_hold"}, 64'({done, busy, err_cnt}), 64'({1'b1, 1'b0, 8'(exp_err)}));
  endtask

  initial begin
    int hs, n_bad, lat, n;
    rst = 1'b1; sw_clr = 1'b0; start = 1'b0; nr_trans = '0;
    op_ready = 1'b0; res_val = 1'b0; result_re = '0; result_im = '0;
    ref_lfsr = SEED;

    vecs[0] = '{10, M_GOOD,     R_ALWAYS,  0, 10, 1'b0};
    vecs[1] = '{5,  M_GOOD,     R_TOGGLE3, 0, 5,  1'b0};
    vecs[2] = '{4,  M_CORRUPT2, R_ALWAYS,  1, 4,  1'b0};
    vecs[3] = '{0,  M_GOOD,     R_ALWAYS,  0, 0,  1'b0};
    vecs[4] = '{3,  M_SILENT,   R_ALWAYS,  0, 3,  1'b1};
    vecs[5] = '{1,  M_GOOD,     R_TOGGLE3, 0, 1,  1'b0};

    #7;
    check_quiet("reset_outputs");
    check("reset_operands", 64'(dut_ops), 64'(exp_ops(SEED)));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_txn(vecs[i].nr, vecs[i].mode, vecs[i].rdy, 1'b1, 400, hs, n_bad, lat);
      check_end($sformatf("vec%0d", i), hs, vecs[i].exp_hs, vecs[i].exp_err, vecs[i].exp_to);
      if (vecs[i].nr == 0) check("zero_trans_done_latency", 64'(lat), 64'd1);
      if (vecs[i].exp_to) check("timeout_latency_window", 64'(lat >= TO && lat <= TO + 4), 64'd1);
    end

    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 24);
      run_txn(n, M_RAND, R_RAND, 1'b1, 2000, hs, n_bad, lat);
      check_end($sformatf("rand%0d", k), hs, n, n_bad, 1'b0);
    end

    // Results never come back: issue stalls at FIFO depth and RUN never ends.
    run_txn(6, M_SILENT, R_ALWAYS, 1'b0, TO + 60, hs, n_bad, lat);
    check("stall_handshakes", 64'(hs), 64'd4);
    check("stall_state", 64'({op_val, busy, done, timeout_flag}), 64'b0100);
    pulse_clear();
    check_quiet("sw_clr_outputs");
    check("sw_clr_operands", 64'(dut_ops), 64'(exp_ops(SEED)));

    // Result arrives before any issue, then a flood to saturate the counter.
    @(negedge clk);
    start = 1'b1; nr_trans = 8'd2;
    @(negedge clk);
    start = 1'b0; op_ready = 1'b0; res_val = 1'b1;
    @(negedge clk);
    res_val = 1'b0;
    check("unexp_single", 64'({unexp_flag, busy, err_cnt}), 64'({1'b1, 1'b1, 8'd1}));
    res_val = 1'b1;
    repeat (300) @(negedge clk);
    res_val = 1'b0;
    check("err_cnt_saturate", 64'(err_cnt), 64'd255);
    pulse_clear();
    check_quiet("unexp_cleared");

    // Asynchronous reset in the middle of an 8-transaction run.
    @(negedge clk);
    start = 1'b1; nr_trans = 8'd8; op_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (op_val && op_ready) n++;
    end
    check("abort_point", 64'(n), 64'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_quiet("async_abort_outputs");
    check("async_abort_operands", 64'(dut_ops), 64'(exp_ops(SEED)));
    op_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ref_lfsr = SEED;
    check("restart_first_operands", 64'(dut_ops), 64'(exp_ops(SEED)));
    run_txn(8, M_GOOD, R_ALWAYS, 1'b1, 400, hs, n_bad, lat);
    check_end("restart", hs, 8, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
